// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT output scheduler.
// Holds the controller state encoding, the bin count and index width,
// the default bin word width and the list of purely real bins.
package fft_sched_pkg;

  localparam int NBINS      = 8;
  localparam int IDX_W      = 3;
  localparam int DW_DEFAULT = 8;

  // Bins 0 (DC) and 4 (Nyquist) of a real-input 8-point FFT carry no imaginary part.
  localparam logic [IDX_W-1:0] REAL_BIN_DC  = 3'd0;
  localparam logic [IDX_W-1:0] REAL_BIN_NYQ = 3'd4;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE      = 2'd0;
  localparam sched_state_t ST_START     = 2'd1;
  localparam sched_state_t ST_WAIT_DONE = 2'd2;
  localparam sched_state_t ST_STREAM    = 2'd3;

  function automatic logic is_real_bin(input logic [IDX_W-1:0] k);
    return (k == REAL_BIN_DC) || (k == REAL_BIN_NYQ);
  endfunction

endpackage

// File: rtl/fft_rate_tick.sv
// Clock-enable divider used to pace output words on fastclk.
// Ports:
//   fastclk - clock
//   rst     - synchronous active-high reset (clears the count)
//   clear   - restart the interval from zero
//   enable  - count only while high
//   tick    - one-cycle pulse when the count reaches DIV-1 while enabled
module fft_rate_tick #(
  parameter int DIV = 25
) (
  input  logic fastclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge fastclk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fft_out_scheduler.sv
// Sequences one 8-point FFT per request and streams the eight result bins
// as complex words over valid/ready, paced by fft_rate_tick.
// Optional watchdog on the FFT done strobe: define FFT_SCHED_TIMEOUT_EN.
// Ports:
//   fastclk, rst          - clock, synchronous active-high reset
//   frame_req, cont       - single request / continuous mode
//   fft_start, fft_done   - FFT core start pulse and result strobe
//   bins_re, bins_im      - packed bin words, bin k at [k*DW +: DW]
//   out_re, out_im, out_index, out_valid, out_ready, out_last - output stream
//   busy                  - controller not idle
//   overrun_cnt           - saturating count of done strobes seen while streaming
//   err                   - sticky watchdog flag (0 without the watchdog)
module fft_out_scheduler
  import fft_sched_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DIV     = 25,
  parameter int TIMEOUT = 1024
) (
  input  logic                fastclk,
  input  logic                rst,
  input  logic                frame_req,
  input  logic                cont,
  output logic                fft_start,
  input  logic                fft_done,
  input  logic [NBINS*DW-1:0] bins_re,
  input  logic [NBINS*DW-1:0] bins_im,
  output logic [DW-1:0]       out_re,
  output logic [DW-1:0]       out_im,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic [7:0]          overrun_cnt,
  output logic                err
);

  sched_state_t   state;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]  frame_re [NBINS];
  logic [DW-1:0]  frame_im [NBINS];

  logic capture;
  logic handshake;
  logic tick;
  logic wd_expire;

  assign capture   = (state == ST_WAIT_DONE) && fft_done;
  assign handshake = out_valid && out_ready;

  // The divider only runs while a word is pending; it restarts on capture
  // and on every accepted word so each word waits a full DIV interval.
  fft_rate_tick #(.DIV(DIV)) u_rate_tick (
    .fastclk (fastclk),
    .rst     (rst),
    .clear   (capture || handshake),
    .enable  ((state == ST_STREAM) && !out_valid),
    .tick    (tick)
  );

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expire = (state == ST_WAIT_DONE) && !fft_done &&
                     (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err       = err_q;

  always_ff @(posedge fastclk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if ((state == ST_WAIT_DONE) && !fft_done) begin
      if (wd_expire) begin
        wd_cnt <= '0;
        err_q  <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge fastclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
      for (int k = 0; k < NBINS; k++) begin
        frame_re[k] <= '0;
        frame_im[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_req || cont) state <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (fft_done) begin
            for (int k = 0; k < NBINS; k++) begin
              frame_re[k] <= bins_re[k*DW +: DW];
              frame_im[k] <= bins_im[k*DW +: DW];
            end
            idx   <= '0;
            state <= ST_STREAM;
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (fft_done && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
          if (tick) out_valid <= 1'b1;
          if (handshake) begin
            out_valid <= 1'b0;
            if (idx == IDX_W'(NBINS - 1)) begin
              idx   <= '0;
              state <= cont ? ST_START : ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The imaginary words of the real bins are stored but masked on output.
  assign out_re    = frame_re[idx];
  assign out_im    = is_real_bin(idx) ? '0 : frame_im[idx];
  assign out_index = idx;
  assign out_last  = out_valid && (idx == IDX_W'(NBINS - 1));
  assign busy      = (state != ST_IDLE);
  assign fft_start = (state == ST_START);

endmodule

// File: tb/tb_fft_out_scheduler.sv
// Self-checking bench for fft_out_scheduler with randomized bin data.
// The expected stream comes from the bins presented at capture time,
// with imaginary parts of bins 0 and 4 forced to zero, and word timing
// predicted from the pacing interval.
module tb_fft_out_scheduler;

  localparam int DW      = 8;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 16;

  logic            fastclk = 1'b0;
  logic            rst, frame_req, cont, fft_done, out_ready;
  logic [8*DW-1:0] bins_re, bins_im;
  logic            fft_start, out_valid, out_last, busy, err;
  logic [DW-1:0]   out_re, out_im;
  logic [2:0]      out_index;
  logic [7:0]      overrun_cnt;

  fft_out_scheduler #(.DW(DW), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .fastclk     (fastclk),
    .rst         (rst),
    .frame_req   (frame_req),
    .cont        (cont),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .bins_re     (bins_re),
    .bins_im     (bins_im),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .err         (err)
  );

  always #5 fastclk = ~fastclk;

  int cyc    = 0;
  int starts = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  always @(posedge fastclk) cyc <= cyc + 1;
  always @(posedge fastclk) if (fft_start) starts <= starts + 1;

  logic [DW-1:0] fr_re [8];
  logic [DW-1:0] fr_im [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_fft_start"}, fft_start, 0);
    chk({pfx, "_out_re"}, out_re, 0);
    chk({pfx, "_out_im"}, out_im, 0);
    chk({pfx, "_out_index"}, out_index, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_last"}, out_last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_overrun"}, overrun_cnt, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  // Present a new frame on the bin inputs and record what should stream out.
  task automatic load_bins(input bit fixed);
    logic [DW-1:0] im;
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = fixed ? DW'(k + 1) : DW'($urandom);
      im       = fixed ? DW'(8'h10 + k) : DW'($urandom);
      bins_re[k*DW +: DW] = fr_re[k];
      bins_im[k*DW +: DW] = im;
      fr_im[k] = (k == 0 || k == 4) ? '0 : im;
    end
  endtask

  // Starts from a negedge in IDLE; returns at the negedge where WAIT_DONE holds.
  task automatic request(input bit use_cont);
    if (use_cont) cont = 1'b1; else frame_req = 1'b1;
    @(negedge fastclk);
    chk("start_pulse", fft_start, 1);
    frame_req = 1'b0;
    @(negedge fastclk);
    chk("start_once", fft_start, 0);
    chk("busy_wait", busy, 1);
  endtask

  // Pulses done after a random delay; e is the first STREAM cycle.
  task automatic give_done(input bit fixed, output int e);
    repeat ($urandom_range(0, 3)) @(negedge fastclk);
    load_bins(fixed);
    fft_done = 1'b1;
    @(negedge fastclk);
    fft_done = 1'b0;
    e = cyc;
    bins_re = {$urandom, $urandom};
    bins_im = {$urandom, $urandom};
  endtask

  // Consume one frame, checking content, spacing and hold stability.
  task automatic collect(input int e, input int hold_idx, input int hold_n,
                         input bit inject, input int stop_idx,
                         output int nw, output int last_h);
    int ref_c = e;
    int k = 0;
    int held = 0;
    bit seen = 0;
    logic [DW-1:0] sre = '0;
    logic [DW-1:0] sim = '0;
    last_h = e;
    for (int g = 0; g < 2000 && k < 8; g++) begin
      if (inject) begin
        fft_done  = (cyc - e == 3) || (cyc - e == 9) || (cyc - e == 15);
        frame_req = (cyc - e == 21);
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk("word_gap", cyc - ref_c, DIV);
          chk("index", out_index, k);
          chk("re", out_re, fr_re[k]);
          chk("im", out_im, fr_im[k]);
          chk("last", out_last, (k == 7));
          sre = out_re;
          sim = out_im;
        end else begin
          chk("hold_index", out_index, k);
          chk("hold_re", out_re, sre);
          chk("hold_im", out_im, sim);
        end
        if (k == stop_idx) begin
          nw = k;
          fft_done = 1'b0;
          frame_req = 1'b0;
          return;
        end
        if (k == hold_idx && held < hold_n) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
          last_h = cyc;
          ref_c = cyc + 1;
          k++;
          seen = 0;
        end
      end else if (seen) begin
        chk("valid_drop", 0, 1);
        seen = 0;
      end
      @(negedge fastclk);
    end
    fft_done = 1'b0;
    frame_req = 1'b0;
    if (k < 8) chk("frame_timeout", k, 8);
    nw = k;
  endtask

  initial begin
    int e, h, n, n1;
    rst = 1'b1; frame_req = 1'b0; cont = 1'b0; fft_done = 1'b0; out_ready = 1'b1;
    bins_re = '0; bins_im = '0;
    repeat (3) @(negedge fastclk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge fastclk);

    // Single frame with known bins, consumer always ready.
    request(0);
    give_done(1, e);
    collect(e, -1, 0, 0, -1, n, h);
    chk("f1_words", n, 8);
    chk("f1_idle", busy, 0);
    chk("f1_starts", starts, 1);

    // Backpressure on index 2, plus stray done strobes and a request mid-stream.
    request(0);
    give_done(0, e);
    collect(e, 2, 20, 1, -1, n, h);
    chk("bp_words", n, 8);
    chk("overrun", overrun_cnt, 3);
    repeat (3) @(negedge fastclk);
    chk("bp_starts", starts, 2);
    chk("bp_idle", busy, 0);

    // Continuous mode for two frames.
    request(1);
    give_done(0, e);
    collect(e, -1, 0, 0, -1, n1, h);
    chk("cont_restart", fft_start, 1);
    chk("cont_gap", cyc - h, 1);
    cont = 1'b0;
    @(negedge fastclk);
    give_done(0, e);
    collect(e, -1, 0, 0, -1, n, h);
    chk("cont_words", n1 + n, 16);
    chk("cont_starts", starts, 4);
    @(negedge fastclk);
    chk("cont_idle", busy, 0);

    // Reset while index 5 is presented, then a fresh frame.
    request(0);
    give_done(0, e);
    collect(e, -1, 0, 0, 5, n, h);
    chk("pre_rst_index", n, 5);
    rst = 1'b1;
    @(negedge fastclk);
    chk_zero("midrst");
    rst = 1'b0;
    @(negedge fastclk);
    request(0);
    give_done(0, e);
    collect(e, -1, 0, 0, -1, n, h);
    chk("post_rst_words", n, 8);
    chk("post_rst_starts", starts, 6);

`ifdef FFT_SCHED_TIMEOUT_EN
    // Withhold done: the watchdog should fire after TIMEOUT cycles in WAIT_DONE.
    request(0);
    repeat (TIMEOUT - 1) @(negedge fastclk);
    chk("wd_err_early", err, 0);
    chk("wd_busy_early", busy, 1);
    @(negedge fastclk);
    chk("wd_err", err, 1);
    chk("wd_idle", busy, 0);
    repeat (3) @(negedge fastclk);
    chk("wd_sticky", err, 1);
    rst = 1'b1;
    @(negedge fastclk);
    rst = 1'b0;
    chk("wd_cleared", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_out_scheduler.md
# fft_out_scheduler

Controller that sequences one 8-point FFT conversion per request and streams the result bins out one per rate tick. Pulses the FFT core's start, waits for its done strobe and captures all eight bins into a frame buffer. It then serializes them as complex words over a valid/ready interface, paced by a clock-enable divider on `fastclk` rather than a derived clock. Sits between the FFT core and the display/UART consumer.

## Interface
- `DW`, 8, bin word width (16 in the combined build)
- `DIV`, 25, pacing interval in `fastclk` cycles; legal range 1..65535
- `TIMEOUT`, 1024, done-watchdog limit in cycles; used only with `FFT_SCHED_TIMEOUT_EN`
- `fastclk` in 1: sole clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `frame_req` in 1: request one conversion; sampled in IDLE only
- `cont` in 1: continuous mode; restart automatically after bin 7
- `fft_start` out 1: one-cycle start pulse to the FFT core
- `fft_done` in 1: FFT core result-valid strobe
- `bins_re` in 8*DW: real parts; bin k occupies `[k*DW +: DW]`
- `bins_im` in 8*DW: imaginary parts, same packing; bins 0 and 4 ignored
- `out_re` out DW: real part of the current bin
- `out_im` out DW: imaginary part of the current bin; 0 for bins 0 and 4
- `out_index` out 3: bin number 0..7
- `out_valid` out 1: output word valid
- `out_ready` in 1: consumer accepts the word
- `out_last` out 1: high with `out_valid` when `out_index`==7
- `busy` out 1: state is not IDLE
- `overrun_cnt` out 8: count of `fft_done` strobes ignored in STREAM; saturates at 255
- `err` out 1: sticky watchdog flag; constant 0 without the macro

## Operation
- States and transitions:
  - IDLE: `frame_req`|`cont` -> START.
  - START: `fft_start`=1 for exactly this cycle; unconditional -> WAIT_DONE.
  - WAIT_DONE: `fft_done` -> STREAM. On the same edge, capture all 16 bin words, set index to 0 and clear the divider.
  - STREAM: serialize. On the handshake with index 7 -> START if `cont`, else IDLE.
- Capture: `bins_*` are sampled only on the WAIT_DONE/`fft_done` edge. Input changes afterwards do not affect the frame being streamed.
- Handshake:
  - Once `out_valid` is high, `out_re`/`out_im`/`out_index`/`out_last` stay stable until the cycle where `out_valid`&`out_ready`.
  - `out_valid` never drops without a handshake.
  - On the handshake, `out_valid` goes low next cycle, index increments and the divider restarts.
- Ignored events:
  - `fft_done` outside WAIT_DONE is ignored. In STREAM it also increments `overrun_cnt`.
  - `frame_req` outside IDLE is ignored and not queued.
- Reset:
  - `rst` overrides all other inputs, including mid-frame. The next state is IDLE.
  - All outputs 0: `fft_start`, `out_re`, `out_im`, `out_index`, `out_valid`, `out_last`, `busy`, `overrun_cnt`, `err`.
  - Divider, buffer and watchdog cleared.
- Arithmetic:
  - Divider width is 16 bits.
  - Index wraps 7 -> 0 only via the state change.
  - No arithmetic on data; words pass through unsigned/unchanged.

## Timing
- Request to start: `frame_req` high in IDLE at cycle C -> `fft_start` high at C+1, WAIT_DONE at C+2.
- Capture to first word: `fft_done` at cycle T -> STREAM entered at E=T+1 -> `out_valid` first high at E+DIV.
- Subsequent words: handshake at cycle H -> next `out_valid` high at H+1+DIV.
- With `out_ready` tied high, words are spaced DIV+1 cycles apart and a frame lasts 8·(DIV+1) cycles after E.
- Back-to-back continuous mode: last handshake at H -> START at H+1.
- DIV=1: `out_valid` the cycle after entry; minimum spacing 2 cycles.

## Configuration
- `FFT_SCHED_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT_DONE.
  - If it reaches TIMEOUT without `fft_done`, `err` is set (sticky until `rst`) and the state goes to IDLE.
  - With `cont`=1 a new START follows.
- Undefined: WAIT_DONE waits indefinitely; `err` is tied 0; no watchdog logic is synthesized.

## Structure
- Package `fft_sched_pkg`:
  - State enum (IDLE, START, WAIT_DONE, STREAM).
  - `NBINS`=8, `IDX_W`=3.
  - Default `DW`.
  - Real-bin indices 0 and 4.
- Sub-module `fft_rate_tick`: 16-bit clock-enable divider with `clear` and `enable` inputs and a one-cycle `tick` output at count DIV-1; this replaces toggled clocks.

## Test plan
- Reset, then one `frame_req` pulse with DIV=4, `out_ready`=1, `bins_re` k=k+1, `bins_im` k=0x10+k:
  - `fft_start` occurs once.
  - Eight words index 0..7 follow, spaced 5 cycles apart.
  - `out_im`=0 at index 0 and 4.
  - `out_last` only on index 7.
- Backpressure: hold `out_ready`=0 for 20 cycles on index 2 -> data and index stay frozen and `out_valid` stays high; after release, index 3 appears 5 cycles after the handshake.
- `fft_done` pulsed 3 times during STREAM, and `frame_req` during STREAM -> `overrun_cnt`=3, frame content unchanged, no extra `fft_start`.
- `cont`=1 for two frames -> second `fft_start` the cycle after the index-7 handshake; 16 words total.
- `rst` asserted during index 5 -> next cycle all outputs 0 and state IDLE; a fresh request streams from index 0.
- With `FFT_SCHED_TIMEOUT_EN` and TIMEOUT=16, `fft_done` withheld -> `err`=1 after 16 WAIT_DONE cycles and state IDLE; `err` holds until `rst`.
